// File: rtl/seg7_scan_ctrl_pkg.sv
// Shared definitions for the seven-segment scan controller.
// Contents: the nibble-to-segment table (g..a, active-high), the reg_sel
// encodings, the CTRL field positions and the CTRL reset value.
package seg7_pkg;

    // Index is the hex nibble; bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    localparam logic REG_SEL_DATA = 1'b0;
    localparam logic REG_SEL_CTRL = 1'b1;

    localparam int CTRL_W      = 16;
    localparam int CTRL_EN_LSB = 0;
    localparam int CTRL_EN_MSB = 7;
    localparam int CTRL_DP_LSB = 8;
    localparam int CTRL_DP_MSB = 15;

    localparam logic [CTRL_W-1:0] CTRL_RST = 16'h00FF;

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Register bus between the address decoder (master) and the display
// controller (slave).
//   seg_ctrl   : one-cycle store strobe
//   reg_sel    : 0 = DATA, 1 = CTRL
//   write_data : store data
//   rdata      : combinational readback of the selected register
interface seg7_scan_ctrl_if;
    logic        seg_ctrl;
    logic        reg_sel;
    logic [31:0] write_data;
    logic [31:0] rdata;

    modport master (output seg_ctrl, output reg_sel, output write_data, input rdata);
    modport slave  (input seg_ctrl, input reg_sel, input write_data, output rdata);
endinterface

// File: rtl/seg7_scan_ctrl_hex_to_seg7.sv
// Combinational hex nibble to seven-segment decoder.
//   nibble : 4-bit hex value
//   seg    : segments {g,f,e,d,c,b,a}, active-high
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);
    assign seg = SEG_TABLE[nibble];
endmodule

// File: rtl/seg7_scan_ctrl.sv
// Memory-mapped eight-digit seven-segment scan controller.
// Holds a 32-bit DATA register and a 16-bit CTRL register (enable mask in
// [7:0], decimal-point mask in [15:8]) and time-multiplexes the digits onto
// a shared segment bus, SCAN_DIV clock cycles per digit.
//   clk, rst  : system clock, synchronous active-high reset
//   bus       : register bus (slave side)
//   digit_en  : one-hot digit enable, digit 0 rightmost
//   seg_out   : segments {dp,g,f,e,d,c,b,a}, active-high
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 100000
)
(
    input  logic             clk,
    input  logic             rst,
    seg7_scan_ctrl_if.slave  bus,
    output logic [7:0]       digit_en,
    output logic [7:0]       seg_out
);
    localparam int unsigned     DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [31:0]       data_reg;
    logic [CTRL_W-1:0] ctrl_reg;
    logic [DIV_W-1:0]  div_cnt;
    logic [2:0]        idx;

    logic [7:0] en_mask;
    logic [7:0] dp_mask;
    logic [3:0] cur_nibble;
    logic [6:0] cur_seg;
    logic       cur_en;

    // Upper half of a CTRL store is discarded.
    logic unused_wdata_hi;
    assign unused_wdata_hi = ^bus.write_data[31:CTRL_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            data_reg <= '0;
            ctrl_reg <= CTRL_RST;
        end else if (bus.seg_ctrl) begin
            if (bus.reg_sel == REG_SEL_CTRL)
                ctrl_reg <= bus.write_data[CTRL_W-1:0];
            else
                data_reg <= bus.write_data;
        end
    end

    assign bus.rdata = (bus.reg_sel == REG_SEL_CTRL) ? {{(32-CTRL_W){1'b0}}, ctrl_reg}
                                                     : data_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            idx     <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            idx     <= idx + 3'd1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign en_mask    = ctrl_reg[CTRL_EN_MSB:CTRL_EN_LSB];
    assign dp_mask    = ctrl_reg[CTRL_DP_MSB:CTRL_DP_LSB];
    assign cur_nibble = data_reg[{idx, 2'b00} +: 4];
    assign cur_en     = en_mask[idx];

    hex_to_seg7 u_dec (
        .nibble (cur_nibble),
        .seg    (cur_seg)
    );

    // Output register samples the live registers every cycle, so a store
    // landing on the slot boundary is shown from the new slot's first cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            digit_en <= '0;
            seg_out  <= '0;
        end else if (cur_en) begin
            digit_en <= 8'b1 << idx;
            seg_out  <= {dp_mask[idx], cur_seg};
        end else begin
            digit_en <= '0;
            seg_out  <= '0;
        end
    end

endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Memory-mapped eight-digit seven-segment display controller. It sits directly downstream of the memory/IO address decoder and captures `write_data` whenever that stage asserts `seg_ctrl`. It holds a 32-bit hex value plus a control word, and time-multiplexes the eight digits onto the board's shared segment bus. It also offers a register readback path so the decoder can return its contents to the register file.

## Interface
Parameters:
- `SCAN_DIV`, 100000: clock cycles per digit slot; legal range 2..2^20.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `seg_ctrl` in 1: write strobe from the address decoder, one cycle per store.
- `reg_sel` in 1: register select. 0 = DATA, 1 = CTRL.
- `write_data` in 32: store data from the decoder.
- `rdata` out 32: readback of the register chosen by `reg_sel`.
- `digit_en` out 8: one-hot digit enable, active-high; bit i = digit i, with digit 0 rightmost.
- `seg_out` out 8: segment drive, active-high, bit order {dp,g,f,e,d,c,b,a}.

## Operation
- DATA register, 32 bits: digit i shows hex nibble DATA[4i+3:4i]. Reset value 0.
- CTRL register, 16 bits used:
  - [7:0] digit enable mask. Reset value 8'hFF.
  - [15:8] decimal-point mask. Reset value 8'h00.
  - Bits [31:16] are ignored on write and read as 0.
- Write behaviour: `seg_ctrl`=1 writes `write_data` into the register chosen by `reg_sel` at the clock edge. No other input modifies the registers.
- `rdata` is combinational: DATA, or {16'h0, CTRL}, selected by `reg_sel`. It is independent of `seg_ctrl`.
- Prescaler `div_cnt` counts 0..SCAN_DIV-1. At the terminal count it wraps to 0 and the digit index `idx` (3 bits) advances, wrapping 7→0.
- Display output register, updated every cycle from the current `idx`, DATA and CTRL:
  - If enable mask bit `idx` is set: `digit_en` = 1<<idx, `seg_out[6:0]` = decode(nibble idx), `seg_out[7]` = dp mask bit idx.
  - If the enable bit is clear: `digit_en` = 0 and `seg_out` = 0. The blanked slot still consumes its full time slot.
- Decode, segments g..a:
  - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
  - 8:7F 9:6F A:77 B:7C C:39 D:5E E:79 F:71
- No state machine beyond the two counters. The scan runs freely and never stalls.

## Timing
- Reset values:
  - `digit_en`=0, `seg_out`=0, `idx`=0, `div_cnt`=0.
  - DATA=0, CTRL=16'h00FF.
- First cycle after `rst` deasserts: outputs show digit 0, i.e. `digit_en`=8'h01 and `seg_out`=8'h3F.
- Write-to-display latency is 2 edges: the register updates at edge N, and the outputs reflect it after edge N+1. `rdata` reflects the write right after edge N.
- Slot length is exactly SCAN_DIV cycles. The full frame is 8·SCAN_DIV cycles.
- A write coinciding with the terminal count: both take effect at the same edge. The new digit is displayed with the new data, with no one-slot glitch of old data.
- `rst` asserted mid-slot or mid-write: all state returns to reset values at that edge, and the pending write is dropped.
- `seg_ctrl` held high for multiple cycles: each cycle rewrites the register. This is idempotent if the data is stable.

## Structure
- Shared package `seg7_pkg`:
  - the 16-entry nibble→segment constant table;
  - the DATA/CTRL `reg_sel` encodings;
  - the CTRL field bit positions;
  - the reset value of CTRL.
- Sub-module `hex_to_seg7`: combinational, 4-bit in, 7-bit out, built from the package table.
- Top module contains only the register file, the two counters and the output register.

## Test plan
- Reset: hold `rst` 3 cycles → during reset `digit_en`=0 and `seg_out`=0; first cycle after release `digit_en`=01, `seg_out`=3F; `rdata` with `reg_sel`=1 reads 0000_00FF.
- Scan and decode (SCAN_DIV=4): write DATA=12345678 → digit 0 shows 7F for 4 cycles, then digit 1 shows 07 (`digit_en`=02), and so on up to digit 7 showing 06 (`digit_en`=80); the 33rd slot-cycle returns to digit 0.
- Masks: write CTRL=0000_F00F → digits 4–7 give `digit_en`=0 and `seg_out`=0 for full slots; digits 0–3 unaffected; dp is set on none of the enabled digits. Then write CTRL=0000_01FF → digit 0 shows `seg_out`=FF.
- Write at slot boundary: write DATA=AAAAAAAA on the terminal-count cycle of digit 2 → digit 3 shows 77 from its first cycle.
- Reset mid-scan: assert `rst` during digit 5, with a simultaneous `seg_ctrl` write of FFFFFFFF → after release DATA reads 0 and the scan restarts at digit 0 with 3F.
- Readback: write CTRL=ABCD1234 → `rdata`=0000_1234 (`reg_sel`=1); DATA readback is unchanged.
